adc_seq_oversampler: RTL and testbench

- Parametrised successor to the current ADC control core.
- Scans a runtime channel mask over N channels of the Altera modular ADC Avalon-ST command/response interface.
- Takes 2^avg_log samples per channel, averages them in hardware, stores one result per channel and raises done/interrupt.
- Sits between the bus register block and the ADC IP. Supports software start, external trigger and free-running modes.

---
 rtl/adc_seq_oversampler.sv | 270 +++++++++++++++++++++++++++
 tb/tb_adc_seq_oversampler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_oversampler.sv
// Scans a channel mask over the modular-ADC command/response stream and averages 2^avg_log samples per channel.
// Latency: one command in flight at a time, so a channel costs 2^avg_log round trips plus one store cycle; a result read takes 1 cycle. Backpressure: cmd fields are held until cmd_ready.
module adc_seq_oversampler #(
    parameter int NCH         = 16,
    parameter int DW          = 12,
    parameter int AVG_MAX_LOG = 4,
    parameter int IDX_W       = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             enable,
    input  logic             start,
    input  logic             trigger,
    input  logic             trig_en,
    input  logic             free_run,
    input  logic [NCH-1:0]   chan_mask,
    input  logic [2:0]       avg_log,
    output logic             cmd_valid,
    output logic [4:0]       cmd_channel,
    output logic             cmd_sop,
    output logic             cmd_eop,
    input  logic             cmd_ready,
    input  logic             rsp_valid,
    input  logic [4:0]       rsp_channel,
    input  logic [DW-1:0]    rsp_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DW-1:0]    rd_data,
    output logic             rd_fresh,
    output logic             busy,
    output logic             done,
    output logic             irq,
    input  logic             irq_clr
);

    localparam int AW = DW + AVG_MAX_LOG;
    localparam int CW = AVG_MAX_LOG + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_FINISH
    } state_t;

    function automatic logic [4:0] lowest_bit(input logic [NCH-1:0] m);
        lowest_bit = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest_bit = 5'(i);
        end
    endfunction

    function automatic logic [4:0] highest_bit(input logic [NCH-1:0] m);
        highest_bit = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) highest_bit = 5'(i);
        end
    endfunction

    function automatic logic [4:0] next_bit(input logic [NCH-1:0] m, input logic [4:0] cur);
        next_bit = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (5'(i) > cur)) next_bit = 5'(i);
        end
    endfunction

    function automatic logic [CW-1:0] last_of(input logic [2:0] a);
        last_of = CW'((32'd1 << a) - 32'd1);
    endfunction

    state_t                  state_q, state_d;
    logic [NCH-1:0]          mask_q, mask_d;
    logic [2:0]              alog_q, alog_d;
    logic [4:0]              ch_q, ch_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic                    first_q, first_d;
    logic [NCH-1:0][DW-1:0]  res_q, res_d;
    logic [NCH-1:0]          fresh_q, fresh_d;
    logic                    trig_q, trig_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic                    clr_arm_q, clr_arm_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic [4:0]              cmd_channel_q, cmd_channel_d;
    logic                    cmd_sop_q, cmd_sop_d;
    logic                    cmd_eop_q, cmd_eop_d;
    logic [DW-1:0]           rd_data_q, rd_data_d;
    logic                    rd_fresh_q, rd_fresh_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    irq_q, irq_d;

    logic [2:0]              alog_clamp;
    logic                    start_ok;
    logic [DW-1:0]           store_val;
    logic                    issue_next;

    assign alog_clamp = (int'(avg_log) > AVG_MAX_LOG) ? 3'(AVG_MAX_LOG) : avg_log;
    assign start_ok   = enable && (|chan_mask) && (start || (trig_en && trigger && !trig_q));
    assign store_val  = DW'(acc_q >> alog_q);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        alog_d    = alog_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        first_d   = first_q;
        res_d     = res_q;
        fresh_d   = fresh_q;
        trig_d    = trigger;
        rd_idx_d  = rd_idx;
        clr_arm_d = 1'b0;
        irq_d     = irq_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    mask_d  = chan_mask;
                    alog_d  = alog_clamp;
                    ch_d    = lowest_bit(chan_mask);
                    cnt_d   = '0;
                    acc_d   = '0;
                    first_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    first_d = 1'b0;
                    state_d = S_WAIT;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // Only the response for the channel in flight counts; strays are dropped.
                if (rsp_valid && (rsp_channel == ch_q)) begin
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else begin
                        acc_d = acc_q + AW'(rsp_data);
                        if (cnt_q < last_of(alog_q)) begin
                            cnt_d   = cnt_q + CW'(1);
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_STORE;
                        end
                    end
                end
            end
            S_STORE: begin
                for (int i = 0; i < NCH; i++) begin
                    if (5'(i) == ch_q) res_d[i] = store_val;
                end
                acc_d     = '0;
                cnt_d     = '0;
                clr_arm_d = 1'b1;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (ch_q == highest_bit(mask_q)) begin
                    state_d = S_FINISH;
                end else begin
                    ch_d    = next_bit(mask_q, ch_q);
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                if (free_run && enable && (|chan_mask)) begin
                    mask_d  = chan_mask;
                    alog_d  = alog_clamp;
                    ch_d    = lowest_bit(chan_mask);
                    cnt_d   = '0;
                    acc_d   = '0;
                    first_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read-clear is applied first so a same-cycle store leaves the flag set.
        for (int i = 0; i < NCH; i++) begin
            if ((rd_idx != rd_idx_q || clr_arm_q) && (IDX_W'(i) == rd_idx)) fresh_d[i] = 1'b0;
            if ((state_q == S_STORE) && (5'(i) == ch_q)) fresh_d[i] = 1'b1;
        end

        if (irq_clr) irq_d = 1'b0;
        if (state_q == S_FINISH) irq_d = 1'b1;

        issue_next    = (state_d == S_ISSUE);
        cmd_valid_d   = issue_next;
        cmd_channel_d = issue_next ? ch_d : 5'd0;
        cmd_sop_d     = issue_next && first_d;
        cmd_eop_d     = issue_next && (cnt_d == last_of(alog_d)) && (ch_d == highest_bit(mask_d));
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_FINISH);

        rd_data_d  = '0;
        rd_fresh_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (IDX_W'(i) == rd_idx) begin
                rd_data_d  = res_q[i];
                rd_fresh_d = fresh_q[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            alog_q        <= '0;
            ch_q          <= '0;
            cnt_q         <= '0;
            acc_q         <= '0;
            first_q       <= 1'b0;
            res_q         <= '0;
            fresh_q       <= '0;
            trig_q        <= 1'b0;
            rd_idx_q      <= '0;
            clr_arm_q     <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_channel_q <= '0;
            cmd_sop_q     <= 1'b0;
            cmd_eop_q     <= 1'b0;
            rd_data_q     <= '0;
            rd_fresh_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            alog_q        <= alog_d;
            ch_q          <= ch_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            first_q       <= first_d;
            res_q         <= res_d;
            fresh_q       <= fresh_d;
            trig_q        <= trig_d;
            rd_idx_q      <= rd_idx_d;
            clr_arm_q     <= clr_arm_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_channel_q <= cmd_channel_d;
            cmd_sop_q     <= cmd_sop_d;
            cmd_eop_q     <= cmd_eop_d;
            rd_data_q     <= rd_data_d;
            rd_fresh_q    <= rd_fresh_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            irq_q         <= irq_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_channel = cmd_channel_q;
    assign cmd_sop     = cmd_sop_q;
    assign cmd_eop     = cmd_eop_q;
    assign rd_data     = rd_data_q;
    assign rd_fresh    = rd_fresh_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_adc_seq_oversampler.sv
// Directed bench for adc_seq_oversampler with a simple ADC responder model.
module tb_adc_seq_oversampler;

    localparam int NCH = 16;
    localparam int DW  = 12;

    logic            CLK = 1'b0;
    logic            RESET, enable, start, trigger, trig_en, free_run;
    logic [NCH-1:0]  chan_mask;
    logic [2:0]      avg_log;
    logic            cmd_valid, cmd_sop, cmd_eop, cmd_ready;
    logic [4:0]      cmd_channel;
    logic            rsp_valid;
    logic [4:0]      rsp_channel;
    logic [DW-1:0]   rsp_data;
    logic [3:0]      rd_idx;
    logic [DW-1:0]   rd_data;
    logic            rd_fresh, busy, done, irq, irq_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int ncmd    = 0;
    int ndone   = 0;
    int rsp_delay = 1;
    logic inject_bad = 1'b0;
    logic [4:0]    log_ch[$];
    logic          log_sop[$];
    logic          log_eop[$];
    logic [DW-1:0] samp_q[$];

    adc_seq_oversampler #(.NCH(NCH), .DW(DW), .AVG_MAX_LOG(4), .IDX_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .start(start), .trigger(trigger),
        .trig_en(trig_en), .free_run(free_run), .chan_mask(chan_mask), .avg_log(avg_log),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_fresh(rd_fresh), .busy(busy), .done(done),
        .irq(irq), .irq_clr(irq_clr)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (!RESET && done) ndone++;

    // ADC model: logs each accepted command and answers it after rsp_delay negedges.
    initial begin : adc_model
        logic [4:0]    ch;
        logic [DW-1:0] s;
        rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
        forever begin
            @(posedge CLK);
            if (!RESET && cmd_valid && cmd_ready) begin
                ch = cmd_channel;
                log_ch.push_back(ch); log_sop.push_back(cmd_sop); log_eop.push_back(cmd_eop);
                ncmd++;
                repeat (rsp_delay) @(negedge CLK);
                if (inject_bad && ch == 5'd4) begin
                    rsp_valid = 1'b1; rsp_channel = 5'd7; rsp_data = 12'hFFF;
                    @(negedge CLK);
                end
                if (samp_q.size() > 0) s = samp_q.pop_front();
                else s = '0;
                rsp_valid = 1'b1; rsp_channel = ch; rsp_data = s;
                @(negedge CLK);
                rsp_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_ncmd(input string tag, input int target, input int budget);
        int k = 0;
        while (ncmd < target && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, {31'd0, ncmd >= target}, 32'd1);
    endtask

    task automatic rd(input int idx);
        rd_idx = 4'(idx);
        @(negedge CLK);
    endtask

    initial begin
        int c0, d0, k;
        logic seen;
        RESET = 1'b1; enable = 1'b1; start = 1'b0; trigger = 1'b0; trig_en = 1'b0;
        free_run = 1'b0; chan_mask = '0; avg_log = '0; cmd_ready = 1'b1;
        rd_idx = 4'd15; irq_clr = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_irq_done", {30'd0, irq, done}, 32'd0);
        chk("rst_rd_data", {20'd0, rd_data}, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Single channel, single sample.
        chan_mask = 16'h0002; avg_log = 3'd0; samp_q.push_back(12'h123);
        c0 = ncmd; d0 = ndone;
        pulse_start();
        wait_idle("t1_idle", 50);
        chk("t1_ncmd", ncmd - c0, 1);
        chk("t1_cmd", {25'd0, log_ch[c0], log_sop[c0], log_eop[c0]}, {25'd0, 5'd1, 1'b1, 1'b1});
        chk("t1_done", ndone - d0, 1);
        chk("t1_irq", {31'd0, irq}, 32'd1);
        rd(1);
        chk("t1_result", {20'd0, rd_data}, 32'h123);
        chk("t1_fresh", {31'd0, rd_fresh}, 32'd1);
        rd_idx = 4'd15;

        // Two channels, four samples each.
        chan_mask = 16'h000C; avg_log = 3'd2;
        samp_q.push_back(12'd100); samp_q.push_back(12'd101);
        samp_q.push_back(12'd102); samp_q.push_back(12'd103);
        repeat (4) samp_q.push_back(12'd4000);
        c0 = ncmd; d0 = ndone;
        pulse_start();
        wait_idle("t2_idle", 200);
        chk("t2_ncmd", ncmd - c0, 8);
        for (int i = 0; i < 8; i++) begin
            if (ncmd - c0 > i)
                chk("t2_cmd", {25'd0, log_ch[c0+i], log_sop[c0+i], log_eop[c0+i]},
                    {25'd0, (i < 4) ? 5'd2 : 5'd3, i == 0, i == 7});
        end
        chk("t2_done", ndone - d0, 1);
        rd(2);
        chk("t2_result2", {20'd0, rd_data}, 32'd101);
        rd(3);
        chk("t2_result3", {20'd0, rd_data}, 32'd4000);
        rd_idx = 4'd15;

        // Trigger edge while busy is ignored, edge while idle starts, trig_en=0 blocks.
        chan_mask = 16'h0001; avg_log = 3'd0; trig_en = 1'b1; cmd_ready = 1'b0;
        samp_q.push_back(12'h055); samp_q.push_back(12'h0AA);
        c0 = ncmd;
        pulse_start();
        trigger = 1'b1; @(negedge CLK); trigger = 1'b0;
        repeat (2) @(negedge CLK);
        cmd_ready = 1'b1;
        wait_idle("t3_idle_a", 50);
        repeat (3) @(negedge CLK);
        chk("t3_busy_edge_ignored", ncmd - c0, 1);
        trigger = 1'b1; @(negedge CLK); trigger = 1'b0;
        chk("t3_trig_start", {31'd0, busy}, 32'd1);
        wait_idle("t3_idle_b", 50);
        chk("t3_ncmd", ncmd - c0, 2);
        rd(0);
        chk("t3_result0", {20'd0, rd_data}, 32'h0AA);
        rd_idx = 4'd15;
        trig_en = 1'b0;
        trigger = 1'b1; repeat (3) @(negedge CLK); trigger = 1'b0;
        repeat (10) @(negedge CLK);
        chk("t3_trig_disabled", ncmd - c0, 2);

        // Free-running back-to-back sequences, then stop after the current one.
        chan_mask = 16'h0030; avg_log = 3'd0; free_run = 1'b1;
        samp_q.push_back(12'h010); samp_q.push_back(12'h020);
        samp_q.push_back(12'h030); samp_q.push_back(12'h040);
        c0 = ncmd; d0 = ndone;
        pulse_start();
        wait_ncmd("t4_reach3", c0 + 3, 200);
        free_run = 1'b0;
        wait_idle("t4_idle", 100);
        chk("t4_ncmd", ncmd - c0, 4);
        for (int i = 0; i < 4; i++) begin
            if (ncmd - c0 > i)
                chk("t4_cmd", {25'd0, log_ch[c0+i], log_sop[c0+i], log_eop[c0+i]},
                    {25'd0, (i % 2 == 0) ? 5'd4 : 5'd5, i % 2 == 0, i % 2 == 1});
        end
        chk("t4_done", ndone - d0, 2);
        rd(4);
        chk("t4_result4", {20'd0, rd_data}, 32'h030);
        rd(5);
        chk("t4_result5", {20'd0, rd_data}, 32'h040);
        rd_idx = 4'd15;
        samp_q.delete();

        // Stalled command holds its fields; stray channel-7 responses are discarded.
        chan_mask = 16'h0010; avg_log = 3'd1; inject_bad = 1'b1; cmd_ready = 1'b0;
        samp_q.push_back(12'd200); samp_q.push_back(12'd300);
        c0 = ncmd;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold", {24'd0, cmd_valid, cmd_channel, cmd_sop, cmd_eop},
                {24'd0, 1'b1, 5'd4, 1'b1, 1'b0});
            @(negedge CLK);
        end
        cmd_ready = 1'b1;
        wait_idle("t5_idle", 100);
        inject_bad = 1'b0;
        chk("t5_ncmd", ncmd - c0, 2);
        if (ncmd - c0 >= 2) chk("t5_eop_last", {31'd0, log_eop[c0+1]}, 32'd1);
        rd(4);
        chk("t5_result4", {20'd0, rd_data}, 32'd250);
        rd_idx = 4'd15;

        // irq_clr clears; enable dropped in WAIT aborts without done or irq.
        irq_clr = 1'b1; @(negedge CLK); irq_clr = 1'b0;
        chk("t6_irq_clr", {31'd0, irq}, 32'd0);
        chan_mask = 16'h0002; avg_log = 3'd1; rsp_delay = 4;
        samp_q.push_back(12'h777);
        c0 = ncmd; d0 = ndone;
        pulse_start();
        wait_ncmd("t6_first_cmd", c0 + 1, 50);
        enable = 1'b0;
        wait_idle("t6_idle", 50);
        chk("t6_ncmd", ncmd - c0, 1);
        chk("t6_no_done", ndone - d0, 0);
        chk("t6_no_irq", {31'd0, irq}, 32'd0);
        enable = 1'b1; rsp_delay = 1;
        rd(1);
        chk("t6_result1_kept", {20'd0, rd_data}, 32'h123);
        rd_idx = 4'd15;

        // irq_clr in the FINISH cycle loses to the set.
        chan_mask = 16'h0001; avg_log = 3'd0; samp_q.push_back(12'h321);
        pulse_start();
        seen = 1'b0; k = 0;
        while (!seen && k < 50) begin
            if (done) seen = 1'b1;
            else begin @(negedge CLK); k++; end
        end
        chk("t7_done_seen", {31'd0, seen}, 32'd1);
        irq_clr = 1'b1; @(negedge CLK); irq_clr = 1'b0;
        chk("t7_irq_set_wins", {31'd0, irq}, 32'd1);
        wait_idle("t7_idle", 20);

        // Reset while a command is stalled in ISSUE.
        chan_mask = 16'h0002; avg_log = 3'd0; cmd_ready = 1'b0;
        c0 = ncmd;
        pulse_start();
        chk("t8_in_issue", {31'd0, cmd_valid}, 32'd1);
        RESET = 1'b1; @(negedge CLK);
        chk("t8_rst_outputs", {28'd0, cmd_valid, busy, irq, done}, 32'd0);
        RESET = 1'b0; cmd_ready = 1'b1;
        rd(1);
        chk("t8_result1_cleared", {20'd0, rd_data}, 32'd0);
        rd(4);
        chk("t8_result4_cleared", {20'd0, rd_data}, 32'd0);
        repeat (5) @(negedge CLK);
        chk("t8_no_cmd", ncmd - c0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
